// File: rtl/watch_disp_scan_if.sv
// watch_disp_scan_if
// Bundles the display-scan signals between the watch time/calibration
// datapath and the scan controller.
//   hour_h_i, hour_l_i, minutes_h_i, minutes_l_i : BCD time digits
//   second_led : 1 Hz square wave (colon source)
//   state_flag : 0 = run, 1..4 = calibrate minutes_l/minutes_h/hour_l/hour_h
//   seg_o      : active-low segments, bit0..6 = a..g, bit7 = dp
//   dig_sel_o  : active-low one-hot digit enables, bit0 = minutes_l
// master: datapath side (drives digits, observes display pins)
// slave : scan controller side
interface watch_disp_scan_if;
    logic [3:0] hour_h_i;
    logic [3:0] hour_l_i;
    logic [3:0] minutes_h_i;
    logic [3:0] minutes_l_i;
    logic       second_led;
    logic [2:0] state_flag;
    logic [7:0] seg_o;
    logic [3:0] dig_sel_o;

    modport master (
        output hour_h_i, hour_l_i, minutes_h_i, minutes_l_i,
        output second_led, state_flag,
        input  seg_o, dig_sel_o
    );

    modport slave (
        input  hour_h_i, hour_l_i, minutes_h_i, minutes_l_i,
        input  second_led, state_flag,
        output seg_o, dig_sel_o
    );
endinterface

// File: rtl/watch_disp_scan.sv
// watch_disp_scan
// Free-running 4-digit 7-segment scan controller for a common-anode display.
// Round-robin scan minutes_l -> minutes_h -> hour_l -> hour_h, an anti-ghosting
// guard at the start of each dwell, calibration-digit blanking at BLINK_HZ and
// registered outputs (1-cycle latency from internal state).
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : watch_disp_scan_if.slave (digits, second_led, state_flag, seg_o, dig_sel_o)
// Build option:
//   DP_COLON_EN - when defined, the hour_l digit's dp shows ~second_led
//                 (colon); otherwise dp is always off and second_led is unused.
module watch_disp_scan #(
    parameter int CLK_FRE  = 50_000_000,
    parameter int FRAME_HZ = 250,
    parameter int GUARD    = 16,
    parameter int BLINK_HZ = 2
) (
    input  logic                clk,
    input  logic                rstn,
    watch_disp_scan_if.slave    bus
);
    localparam int DWELL = CLK_FRE / (4 * FRAME_HZ);
    localparam int HALF  = CLK_FRE / (2 * BLINK_HZ);

    localparam logic [25:0] DWELL_LAST = 26'(DWELL - 1);
    localparam logic [25:0] HALF_LAST  = 26'(HALF - 1);
    localparam logic [25:0] GUARD_CNT  = 26'(GUARD);

    logic [25:0]      cnt;
    logic [25:0]      blink_cnt;
    logic [1:0]       idx;
    logic             blink_ph;
    logic [3:0][3:0]  snap;      // indexed by idx: 0 = minutes_l .. 3 = hour_h
    logic [7:0]       seg_q;
    logic [3:0]       sel_q;
    logic [7:0]       seg_d;
    logic [3:0]       sel_d;
    logic             dwell_end;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // non-BCD shows '-'
        endcase
        return s;
    endfunction

    assign dwell_end = (cnt == DWELL_LAST);

    always_comb begin
        seg_d      = 8'hFF;
        seg_d[6:0] = bcd_to_seg(snap[idx]);
        // state_flag is compared live so a calibration change shows next cycle
        if ((bus.state_flag == ({1'b0, idx} + 3'd1)) && blink_ph)
            seg_d[6:0] = 7'h7F;
`ifdef DP_COLON_EN
        // colon is never blanked by calibration blink
        if (idx == 2'd2)
            seg_d[7] = ~bus.second_led;
`endif
        sel_d = (cnt < GUARD_CNT) ? 4'hF : ~(4'b0001 << idx);
    end

`ifndef DP_COLON_EN
    logic unused_second_led;
    assign unused_second_led = bus.second_led;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            snap      <= '0;
            seg_q     <= 8'hFF;
            sel_q     <= 4'hF;
        end else begin
            seg_q <= seg_d;
            sel_q <= sel_d;

            if (dwell_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 26'd1;
            end

            // load on the last cycle of hour_h so the next frame is coherent
            if (dwell_end && (idx == 2'd3)) begin
                snap[0] <= bus.minutes_l_i;
                snap[1] <= bus.minutes_h_i;
                snap[2] <= bus.hour_l_i;
                snap[3] <= bus.hour_h_i;
            end

            if (blink_cnt == HALF_LAST) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
        end
    end

    assign bus.seg_o     = seg_q;
    assign bus.dig_sel_o = sel_q;
endmodule

// File: tb/tb_watch_disp_scan.sv
// tb_watch_disp_scan
// Directed stimulus with a cycle-count based reference model of the display
// scan plus literal expectations at hand-picked edges.
module tb_watch_disp_scan;
    localparam int CLK_FRE  = 800;
    localparam int FRAME_HZ = 25;
    localparam int GUARD    = 2;
    localparam int BLINK_HZ = 10;
    localparam int DWELL    = CLK_FRE / (4 * FRAME_HZ);  // 8
    localparam int FRAME    = 4 * DWELL;                 // 32
    localparam int HALF     = CLK_FRE / (2 * BLINK_HZ);  // 40

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF
    };

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    int   e;                 // edges since reset release
    logic [3:0] msnap [4];   // model snapshot: 0 = minutes_l .. 3 = hour_h

    watch_disp_scan_if bus ();

    watch_disp_scan #(
        .CLK_FRE (CLK_FRE),
        .FRAME_HZ(FRAME_HZ),
        .GUARD   (GUARD),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at e=%0d: sel/seg got %h expected %h", nm, e, act, exp);
        end
    endtask

    // Reference model: state after edge e-1 follows directly from the edge count.
    always @(posedge clk) begin
        int c, k, ph;
        logic [7:0] es, pat;
        logic [3:0] esel;
        if (!rstn) begin
            e = 0;
            for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
            es   = 8'hFF;
            esel = 4'hF;
        end else begin
            e    = e + 1;
            c    = (e - 1) % DWELL;
            k    = ((e - 1) / DWELL) % 4;
            ph   = ((e - 1) / HALF) % 2;
            pat  = SEG_TAB[msnap[k]];
            es   = {1'b1, pat[6:0]};
            if ((int'(bus.state_flag) == k + 1) && (ph == 1)) es[6:0] = 7'h7F;
`ifdef DP_COLON_EN
            if (k == 2) es[7] = ~bus.second_led;
`endif
            esel = (c < GUARD) ? 4'hF : ~(4'b0001 << k);
            if (e % FRAME == 0) begin
                msnap[0] = bus.minutes_l_i;
                msnap[1] = bus.minutes_h_i;
                msnap[2] = bus.hour_l_i;
                msnap[3] = bus.hour_h_i;
            end
        end
        #1;
        chk("model", {bus.dig_sel_o, bus.seg_o}, {esel, es});
    end

    task automatic wait_e(input int target);
        int guard_cnt;
        guard_cnt = 0;
        @(negedge clk);
        while (e < target && guard_cnt < 2000) begin
            @(negedge clk);
            guard_cnt++;
        end
        if (e != target) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL wait_e: reached e=%0d required %0d", e, target);
        end
    endtask

    task automatic lit(input string nm, input int target, input logic [3:0] sel, input logic [7:0] seg);
        wait_e(target);
        chk(nm, {bus.dig_sel_o, bus.seg_o}, {sel, seg});
    endtask

    task automatic set_digits(input logic [3:0] hh, input logic [3:0] hl,
                              input logic [3:0] mh, input logic [3:0] ml);
        bus.hour_h_i    = hh;
        bus.hour_l_i    = hl;
        bus.minutes_h_i = mh;
        bus.minutes_l_i = ml;
    endtask

    initial begin
        logic [7:0] blank_seg, hl9_seg, hl0_seg;
        checks   = 0;
        failures = 0;
        e        = 0;
`ifdef DP_COLON_EN
        blank_seg = 8'h7F;
        hl9_seg   = 8'h10;
        hl0_seg   = 8'h40;
`else
        blank_seg = 8'hFF;
        hl9_seg   = 8'h90;
        hl0_seg   = 8'hC0;
`endif
        rstn           = 1'b0;
        bus.second_led = 1'b0;
        bus.state_flag = 3'd0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        chk("reset_hold", {bus.dig_sel_o, bus.seg_o}, 12'hFFF);
        rstn = 1'b1;

        lit("rel_edge1", 1, 4'hF, 8'hC0);
        lit("rel_edge2", 2, 4'hF, 8'hC0);
        lit("rel_edge3", 3, 4'hE, 8'hC0);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);

        lit("scan_ml", 35, 4'hE, 8'h99);
        lit("guard_mh", 41, 4'hF, 8'hB0);
        set_digits(4'd5, 4'd9, 4'd5, 4'd9);   // mid-frame change, idx == 1
        lit("coh_mh", 43, 4'hD, 8'hB0);
        lit("coh_hl", 51, 4'hB, 8'hA4);
        lit("coh_hh", 59, 4'h7, 8'hF9);
        lit("new_ml", 67, 4'hE, 8'h90);
        lit("new_mh", 75, 4'hD, 8'h92);
        lit("new_hl", 83, 4'hB, 8'h90);
        lit("new_hh", 91, 4'h7, 8'h92);

        wait_e(100);
        bus.state_flag = 3'd3;
        bus.second_led = 1'b1;
        lit("blink_dark", 147, 4'hB, blank_seg);
        lit("blink_lit", 179, 4'hB, hl9_seg);

        wait_e(200);
        bus.state_flag = 3'd5;
        lit("flag5_noblank", 211, 4'hB, hl9_seg);

        wait_e(260);
        bus.minutes_l_i = 4'hC;
        lit("bad_bcd", 291, 4'hE, 8'hBF);

        wait_e(300);
        rstn = 1'b0;
        #1;
        chk("async_reset", {bus.dig_sel_o, bus.seg_o}, 12'hFFF);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        lit("rst2_ml", 3, 4'hE, 8'hC0);
        lit("rst2_mh", 11, 4'hD, 8'hC0);
        lit("rst2_hl", 19, 4'hB, hl0_seg);
        lit("rst2_hh", 27, 4'h7, 8'hC0);
        wait_e(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/watch_disp_scan.md
# watch_disp_scan

Time-multiplexed 4-digit 7-segment scan controller for the digital watch. It shares one segment bus among the four time digits (hour_h, hour_l, minutes_h, minutes_l) using a fixed round-robin scan. It also blanks the digit currently under calibration at a blink rate, and drives the colon (decimal point) from the second pulse. It sits between the watch time/calibration datapath and the board's common-anode display pins.

## Interface
Parameters:
- CLK_FRE, 50_000_000: clock frequency in Hz.
- FRAME_HZ, 250: full 4-digit refresh rate. Per-digit dwell DWELL = CLK_FRE/(4*FRAME_HZ) cycles.
- GUARD, 16: anti-ghosting off-time at the start of each dwell, in cycles. Must satisfy GUARD < DWELL.
- BLINK_HZ, 2: calibration blink rate. Half-period HALF = CLK_FRE/(2*BLINK_HZ) cycles.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- hour_h_i, hour_l_i, minutes_h_i, minutes_l_i  in  4 each  BCD digits.
- second_led  in  1  1 Hz square wave.
- state_flag  in  3  calibration state: 0 = run, 1..4 = calibrate digit minutes_l / minutes_h / hour_l / hour_h.
- seg_o  out  8  segments, active-low; bit0..6 = a..g, bit7 = dp.
- dig_sel_o  out  4  digit enables, active-low one-hot; bit0 = minutes_l … bit3 = hour_h.

## Operation
- dwell counter `cnt` runs 0..DWELL-1 and wraps. At cnt==DWELL-1, digit index `idx` advances 0→1→2→3→0.
- idx maps to digits as follows: 0 = minutes_l, 1 = minutes_h, 2 = hour_l, 3 = hour_h.
- Snapshot registers hold all four digit inputs. They load on the edge where cnt==DWELL-1 and idx==3, so each frame shows one coherent time. Inputs are ignored at all other times.
- The blink counter runs 0..HALF-1. `blink_ph` toggles at each wrap.
- Blanking: if state_flag==idx+1 and blink_ph==1, seg_o[6:0] = 7'h7F (digit dark). state_flag 0 or 5..7 never blanks. state_flag is used live, not snapshotted.
- Decode (active-low, bit7 = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Values 10..15 show '-' = BF.
- Guard: while cnt < GUARD, dig_sel_o = 4'hF. seg_o still carries the new digit's pattern during the guard.
- The block is free-running. It has no handshake, and there are no idle or stall states.

## Timing
- Reset (async assert, any cycle) forces:
  - seg_o = 8'hFF, dig_sel_o = 4'hF.
  - cnt = 0, idx = 0, blink counter = 0, blink_ph = 0, snapshots = 0.
- The first frame after reset therefore displays 0000.
- Outputs are registered. seg_o and dig_sel_o at edge n+1 are a function of cnt, idx, snapshot, blink_ph, state_flag and second_led as they stand after edge n. This gives 1-cycle latency.
- After rstn deasserts, the first enabled output is dig_sel_o = 4'b1110. It appears at the edge after cnt reaches GUARD and stays for DWELL-GUARD cycles.
- An input change lands within at most 1 frame + 1 cycle.
- A state_flag change lands within 1 cycle, and blanking starts at the current blink_ph.
- A blink_ph toggle mid-dwell takes effect on the next cycle. No dwell alignment is done.
- Counter widths are 26 bits. Each counter wraps exactly at its terminal value, with no overflow state.

## Configuration
- Macro: DP_COLON_EN.
- Defined: on digit idx 2 (hour_l), seg_o[7] = ~second_led (colon blinks at 1 Hz). The dp is not blanked by calibration blink. All other digits keep dp = 1.
- Undefined: seg_o[7] = 1 always, and second_led is unused.

## Test plan
Sim params for all scenarios: CLK_FRE=800, FRAME_HZ=25 (DWELL=8), GUARD=2, BLINK_HZ=10 (HALF=40).
- Reset: pull rstn low mid-dwell → seg_o=FF and dig_sel_o=F in the same cycle. Release → first frame shows C0 on all four digits, and dig_sel_o=1110 appears at the 3rd edge after release.
- Scan: inputs 1,2,3,4 (hour_h..minutes_l) held for 2 frames → second frame shows the sequence 1110/99, 1101/B0, 1011/A4, 0111/F9. Each digit is enabled 6 cycles and preceded by 2 cycles of F.
- Coherence: change inputs to 5,9,5,9 while idx==1 → idx 1..3 still show B0, A4, F9. The next frame shows 90, 92, 90, 92.
- Blink: state_flag=3 → digit 1011 alternates A4 and FF every 40 cycles. The other three digits are unchanged. With state_flag=5, no digit ever blanks.
- Invalid BCD: minutes_l_i=4'hC → digit 1110 shows BF.
- Macro: with DP_COLON_EN and second_led=1 → digit 1011 shows 24 (0 while blanked, blink_ph=1). Without the macro → A4.
